// File: rtl/button_debouncer.sv
// Pushbutton conditioner: two-flop synchroniser plus a press/release debounce FSM.
// Optional abort counter output enabled by defining BUTTON_DEBOUNCER_GLITCH_CNT_EN.
module button_debouncer #(
   parameter int unsigned STABLE_CYCLES  = 500000,
   parameter int unsigned CNT_W          = 19,
   parameter bit          RAW_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Btt_raw,
   output logic       Btt_clean
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam logic             REL_LVL = logic'(RAW_ACTIVE_LOW);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } state_e;

   logic             sync1_q, sync2_q;
   logic             pressed_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clean_q, clean_d;
   logic             abort_c;

   // sync1 may go metastable; only sync2 ever samples it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= REL_LVL;
         sync2_q <= REL_LVL;
      end else begin
         sync1_q <= Btt_raw;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_s = sync2_q ^ REL_LVL;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   // Next-state: a new level must survive STABLE_CYCLES checks before the output follows
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      abort_c = 1'b0;
      case (state_q)
         IDLE: begin
            clean_d = 1'b0;
            cnt_d   = '0;
            if (pressed_s) state_d = PRESS_CHK;
         end
         PRESS_CHK: begin
            clean_d = 1'b0;
            if (!pressed_s) begin
               state_d = IDLE;
               cnt_d   = '0;
               abort_c = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               clean_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            clean_d = 1'b1;
            cnt_d   = '0;
            if (!pressed_s) state_d = RELEASE_CHK;
         end
         RELEASE_CHK: begin
            clean_d = 1'b1;
            if (pressed_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
               abort_c = 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               clean_d = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clean_d = 1'b0;
         end
      endcase
   end

   assign Btt_clean = clean_q;

`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
   logic [7:0] glitch_q, glitch_d;

   // Saturating count of aborted checks, for judging switch quality
   always_comb begin
      glitch_d = glitch_q;
      if (abort_c && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) glitch_q <= 8'd0;
      else      glitch_q <= glitch_d;
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule
